excess3_to_bcd_stream: RTL and testbench
========================================

EXCESS3_TO_BCD_STREAM -- requirements
Module: excess3_to_bcd_stream

Interface
- REQ-001 Parameter: DIGITS, default 4, number of BCD digits packed per output word (legal range 1..8).
- REQ-002 Port: clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-003 Port: rst, input, 1, synchronous active-high reset, sampled on rising clk.
- REQ-004 Port: in_code, input, 4, one Excess-3 digit.
- REQ-005 Port: in_valid, input, 1, in_code/in_last valid this cycle.
- REQ-006 Port: in_last, input, 1, current digit terminates the word early.
- REQ-007 Port: in_ready, output, 1, block accepts a digit this cycle.
- REQ-008 Port: out_data, output, 4*DIGITS, packed BCD word; first accepted digit most significant.
- REQ-009 Port: out_ndig, output, $clog2(DIGITS+1), number of digits in out_data.
- REQ-010 Port: out_err, output, 1, at least one invalid code in this word.
- REQ-011 Port: out_valid, output, 1, output word valid.
- REQ-012 Port: out_ready, input, 1, downstream accepts the word.

Function
- REQ-013 Digit accepted when in_valid && in_ready.
- REQ-014 Valid codes 0011..1100 decode to in_code minus 3 (BCD 0..9), 4-bit modulo arithmetic.
- REQ-015 Codes 0000..0010 and 1101..1111 are invalid: decoded digit forced to 0000 and word error flag set (sticky until word handed off).
- REQ-016 FSM states: COLLECT (in_ready=1, out_valid=0) and OUTPUT (in_ready=0, out_valid=1).
- REQ-017 In COLLECT each accepted digit shifts into the data register from the LSB end (data <= {data[4*DIGITS-5:0], digit}) and the digit count increments.
- REQ-018 COLLECT -> OUTPUT on the accept that makes count == DIGITS, or on any accept with in_last=1.
- REQ-019 out_valid asserts the cycle after the terminating digit is accepted (latency 1).
- REQ-020 Early-terminated word is right-aligned; unused upper digits read 0000; out_ndig = digits received.
- REQ-021 out_data, out_ndig, out_err SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-022 OUTPUT -> COLLECT on out_valid && out_ready; data, count, error flag cleared in the same edge.
- REQ-023 in_ready deasserted throughout OUTPUT; no digit accepted during handoff (throughput: one word per count+1 cycles minimum).
- REQ-024 in_last on the DIGITS-th digit behaves identically to a full word (no extra empty word).
- REQ-025 in_valid=0 cycles in COLLECT leave all state unchanged.

Reset
- REQ-026 rst=1 forces COLLECT, data register 0, count 0, error flag 0 on the next rising clk.
- REQ-027 Reset values: in_ready=1, out_valid=0, out_data=0, out_ndig=0, out_err=0 (and err_cnt=0 when compiled in).
- REQ-028 rst mid-word or during OUTPUT discards the partial/pending word; no output produced for it.
- REQ-029 rst dominates in_valid and out_ready in the same cycle.

Configuration
- REQ-030 Macro EXCESS3_ERR_CNT_EN defined: extra output port err_cnt, 8 bits, counts every accepted invalid code, saturates at 255, cleared only by rst.
- REQ-031 Macro undefined: err_cnt port and counter absent; all other behaviour identical.

Structure
- REQ-032 Package excess3_pkg holds the EXCESS3_OFFSET constant (4'd3), min/max valid code constants (4'b0011, 4'b1100), and the FSM state typedef.
- REQ-033 Sub-module excess3_digit_dec (combinational: in_code -> 4-bit digit, invalid flag) instantiated once.

Verification (DIGITS=4)
- REQ-034 Codes 0100,0101,0110,0111 with out_ready=1 -> out_data=16'h1234, out_ndig=4, out_err=0, out_valid exactly one cycle, asserted one cycle after the 4th accept.
- REQ-035 Codes 1100,0011 with in_last=1 on 0011 -> out_data=16'h0090, out_ndig=2, out_err=0.
- REQ-036 Codes 0100,1111,0110,0111 -> out_data=16'h1034, out_err=1; err_cnt=1 when EXCESS3_ERR_CNT_EN defined.
- REQ-037 Full word, out_ready held 0 for 5 cycles -> outputs stable, in_ready=0, in_valid digits ignored; word accepted on first out_ready=1 cycle, in_ready=1 next cycle.
- REQ-038 rst asserted after 2 accepted digits -> next word 0100,0100,0100,0100 yields 16'h1111, out_ndig=4, out_err=0.
- REQ-039 Loopback: every code 0..9 through the team's BCD_to_Excess3 converter into this block -> recovered digits equal originals, out_err=0.

Source files
------------

// File: rtl/excess3_pkg.sv
// Shared constants and FSM state encoding for the Excess-3 to BCD stream packer.
package excess3_pkg;

  localparam logic [3:0] EXCESS3_OFFSET   = 4'd3;
  localparam logic [3:0] EXCESS3_MIN_CODE = 4'b0011;
  localparam logic [3:0] EXCESS3_MAX_CODE = 4'b1100;

  localparam int unsigned ERR_CNT_W = 8;

  typedef logic [0:0] state_t;

  localparam state_t ST_COLLECT = 1'b0;
  localparam state_t ST_OUTPUT  = 1'b1;

endpackage

// File: rtl/excess3_digit_dec.sv
// Combinational single-digit Excess-3 decoder; out-of-range codes yield 0 and flag invalid.
module excess3_digit_dec
  import excess3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] digit,
  output logic       invalid
);

  always_comb begin
    invalid = (code < EXCESS3_MIN_CODE) || (code > EXCESS3_MAX_CODE);
    digit   = invalid ? 4'd0 : 4'(code - EXCESS3_OFFSET);
  end

endmodule

// File: rtl/excess3_to_bcd_stream.sv
// Packs a stream of Excess-3 digits into BCD words of up to DIGITS digits.
// Optional saturating invalid-code counter port err_cnt when EXCESS3_ERR_CNT_EN is defined.
module excess3_to_bcd_stream
  import excess3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     in_code,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [4*DIGITS-1:0]            out_data,
  output logic [$clog2(DIGITS+1)-1:0]    out_ndig,
  output logic                           out_err,
  output logic                           out_valid,
`ifdef EXCESS3_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0]           err_cnt,
`endif
  input  logic                           out_ready
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [3:0]    digit;
  logic          invalid;
  logic          accept;

  excess3_digit_dec u_dec (
    .code    (in_code),
    .digit   (digit),
    .invalid (invalid)
  );

  assign accept = in_valid && (state_q == ST_COLLECT);

  // State and word registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Next-state: shift digits in from the LSB end, hand the word off when downstream takes it
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = err_q;
    if (state_q == ST_COLLECT) begin
      if (in_valid) begin
        data_d  = DW'({data_q, digit});
        count_d = count_q + CW'(1);
        err_d   = err_q | invalid;
        if ((count_d == CW'(DIGITS)) || in_last) begin
          state_d = ST_OUTPUT;
        end
      end
    end else begin
      if (out_ready) begin
        state_d = ST_COLLECT;
        data_d  = '0;
        count_d = '0;
        err_d   = 1'b0;
      end
    end
  end

  assign in_ready  = (state_q == ST_COLLECT);
  assign out_valid = (state_q == ST_OUTPUT);
  assign out_data  = data_q;
  assign out_ndig  = count_q;
  assign out_err   = err_q;

`ifdef EXCESS3_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Lifetime count of accepted invalid codes, saturating, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (accept && invalid && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_excess3_to_bcd_stream.sv
// Randomized self-checking bench for excess3_to_bcd_stream (DIGITS=4) against an arithmetic reference model.
module tb_excess3_to_bcd_stream;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DW     = 4 * DIGITS;
  localparam int unsigned CW     = $clog2(DIGITS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_code;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ndig;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;
`ifdef EXCESS3_ERR_CNT_EN
  logic [7:0]    err_cnt;
  int            exp_err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] stim_q[$];

  excess3_to_bcd_stream #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ndig  (out_ndig),
    .out_err   (out_err),
    .out_valid (out_valid),
`ifdef EXCESS3_ERR_CNT_EN
    .err_cnt   (err_cnt),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic bit ref_bad(input logic [3:0] c);
    int v;
    v = int'(c);
    return !(v >= 3 && v <= 12);
  endfunction

  function automatic int ref_digit(input logic [3:0] c);
    if (ref_bad(c)) return 0;
    return int'(c) - 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends stim_q as one word, checks the produced word, holds it for 'stall' cycles, then hands it off.
  task automatic run_word(input bit use_last, input int stall, input bit gaps, input string name);
    int   n;
    logic [31:0] exp;
    bit   exp_err;
    n = stim_q.size();
    exp = 0;
    exp_err = 1'b0;
    out_ready = (stall == 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_code  = 4'($urandom);
          in_last  = 1'($urandom);
          tick();
        end
      end
      in_code  = stim_q[i];
      in_valid = 1'b1;
      in_last  = use_last && (i == n - 1);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s in_ready before digit %0d: got %b expected 1", name, i, in_ready);
      end
      tick();
      exp = exp * 16 + 32'(ref_digit(stim_q[i]));
      if (ref_bad(stim_q[i])) begin
        exp_err = 1'b1;
`ifdef EXCESS3_ERR_CNT_EN
        if (exp_err_cnt < 255) exp_err_cnt++;
`endif
      end
      if (i < n - 1) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early out_valid after digit %0d: got %b expected 0", name, i, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s handshake: got out_valid=%b in_ready=%b expected 1/0", name, out_valid, in_ready);
    end
    n_checks++;
    if (out_data !== DW'(exp)) begin
      n_fail++;
      $display("FAIL %s out_data: got %h expected %h", name, out_data, DW'(exp));
    end
    n_checks++;
    if (out_ndig !== CW'(n)) begin
      n_fail++;
      $display("FAIL %s out_ndig: got %0d expected %0d", name, out_ndig, n);
    end
    n_checks++;
    if (out_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s out_err: got %b expected %b", name, out_err, exp_err);
    end
`ifdef EXCESS3_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'(exp_err_cnt)) begin
      n_fail++;
      $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, exp_err_cnt);
    end
`endif
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom);
      in_code  = 4'($urandom);
      in_last  = 1'($urandom);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== DW'(exp) ||
          out_ndig !== CW'(n) || out_err !== exp_err) begin
        n_fail++;
        $display("FAIL %s stall %0d: got v=%b r=%b d=%h n=%0d e=%b expected v=1 r=0 d=%h n=%0d e=%b",
                 name, s, out_valid, in_ready, out_data, out_ndig, out_err, DW'(exp), n, exp_err);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_ndig !== '0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s handoff: got v=%b r=%b d=%h n=%0d e=%b expected v=0 r=1 d=0 n=0 e=0",
               name, out_valid, in_ready, out_data, out_ndig, out_err);
    end
  endtask

  task automatic check_reset_state(input string name);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_ndig !== '0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got r=%b v=%b d=%h n=%0d e=%b expected r=1 v=0 d=0 n=0 e=0",
               name, in_ready, out_valid, out_data, out_ndig, out_err);
    end
`ifdef EXCESS3_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL %s err_cnt: got %0d expected 0", name, err_cnt);
    end
    exp_err_cnt = 0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_code = 4'b0100; in_last = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check_reset_state("reset");
  endtask

  task automatic test_directed();
    stim_q = '{4'b0100, 4'b0101, 4'b0110, 4'b0111};
    run_word(1'b0, 0, 1'b0, "word_1234");
    stim_q = '{4'b1100, 4'b0011};
    run_word(1'b1, 0, 1'b0, "word_0090");
    stim_q = '{4'b0100, 4'b1111, 4'b0110, 4'b0111};
    run_word(1'b0, 0, 1'b0, "word_1034_err");
    stim_q = '{4'b0000, 4'b1101, 4'b0011, 4'b1100};
    run_word(1'b1, 0, 1'b0, "full_with_last");
  endtask

  task automatic test_backpressure();
    stim_q = '{4'b0100, 4'b0101, 4'b0110, 4'b0111};
    run_word(1'b0, 5, 1'b0, "backpressure");
    stim_q = '{4'b1010, 4'b1011, 4'b1100, 4'b0011};
    run_word(1'b0, 0, 1'b0, "after_backpressure");
  endtask

  task automatic test_reset_midword();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_code = 4'b1111; in_last = 1'b0;
      tick();
    end
    rst = 1'b1; in_valid = 1'b1; in_code = 4'b0000;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_reset_state("reset_midword");
    stim_q = '{4'b0100, 4'b0100, 4'b0100, 4'b0100};
    run_word(1'b0, 0, 1'b0, "word_1111");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_code = 4'b1001; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("reset_in_output");
    out_ready = 1'b1;
  endtask

  task automatic test_loopback();
    for (int base = 0; base < 10; base += 4) begin
      stim_q.delete();
      for (int d = base; d < base + 4 && d < 10; d++) stim_q.push_back(4'(d + 3));
      run_word(stim_q.size() < 4, 0, 1'b1, "loopback");
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 40; w++) begin
      int len;
      bit use_last;
      len = $urandom_range(1, 4);
      stim_q.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) stim_q.push_back(4'($urandom));
        else stim_q.push_back(4'($urandom_range(3, 12)));
      end
      use_last = (len < 4) ? 1'b1 : 1'($urandom);
      run_word(use_last, $urandom_range(0, 3), 1'b1, "random");
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_code = 4'd0; out_ready = 1'b0;
`ifdef EXCESS3_ERR_CNT_EN
    exp_err_cnt = 0;
`endif
    repeat (3) tick();
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midword();
    test_loopback();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
